ray_column_buffer: RTL and testbench
====================================

# ray_column_buffer

Double-buffered column store at the output end of the DDA raycaster. Consumes the 38-bit per-ray result stream emitted by the DDA stage, writes each record into a write bank indexed by its ray column, and on the frame's last ray hands the completed bank to the renderer. The bank swap happens at the renderer's frame boundary. The renderer reads column records by address with fixed latency, so it never sees a partially written frame.

## Interface
- SCREEN_WIDTH, 320: number of ray columns per frame; bank depth.
- REC_WIDTH, 29: stored record width, equal to tdata[28:0].
- pixel_clk_in  input  1  sole clock, all logic on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- dda_out_tvalid_in  input  1  stream beat valid.
- dda_out_tdata_in  input  38  beat payload, packed as follows:
  - [37:29] hcount_ray
  - [28:21] lineHeight
  - [20] wallType
  - [19:16] mapData
  - [15:0] wallX
- dda_out_tlast_in  input  1  marks the last ray of a frame.
- dda_out_tready_out  output  1  buffer accepts a beat this cycle.
- frame_start_in  input  1  single-cycle pulse from the renderer at its frame boundary.
- rd_en_in  input  1  read request.
- rd_addr_in  input  9  column to read.
- rd_valid_out  output  1  rd_data_out is valid.
- rd_data_out  output  29  record {lineHeight, wallType, mapData, wallX}.
- frame_ready_out  output  1  the read bank holds a complete frame.
- frames_done_out  output  16  number of completed swaps (stats feature).
- error_out  output  1  sticky protocol error (stats feature).

## Operation
- Storage: two banks of SCREEN_WIDTH × REC_WIDTH, each with a synchronous write and a registered read. The wr_bank and rd_bank selectors always differ.
- FSM states:
  - FILL: dda_out_tready_out=1.
  - DONE: dda_out_tready_out=0.
- Transitions:
  - FILL → DONE on an accepted beat with tlast=1.
  - DONE → FILL on frame_start_in. In the same edge, wr_bank and rd_bank exchange, the column counter clears, frame_ready_out is set, and frames_done_out increments.
- Accepted beat (tvalid && tready): writes tdata[28:0] to wr_bank[hcount_ray] and increments a 9-bit column counter.
- Out-of-range hcount_ray (≥ SCREEN_WIDTH): the beat is accepted but not written, and an error is flagged.
- Duplicate hcount within a frame: the later beat overwrites the earlier one. This is not an error.
- tlast beat with column counter ≠ SCREEN_WIDTH-1 (short or long frame): the frame still completes, and an error is flagged.
- frame_start_in during FILL: ignored. The read bank is unchanged and the renderer redraws the previous frame.
- Simultaneous tlast acceptance and frame_start_in: the beat is written and the FSM goes to DONE. No swap occurs in that cycle; the swap needs the next frame_start_in.
- Read path:
  - The bank is selected by the rd_bank value sampled in the rd_en_in cycle, so a swap in flight does not corrupt a pending read.
  - rd_addr_in ≥ SCREEN_WIDTH returns 0.
  - Reads before the first swap (frame_ready_out=0) return 0.
- Reset (asynchronous, any time, including mid-frame): state FILL, wr_bank=0, rd_bank=1, counter 0, frame_ready_out=0, rd_valid_out=0, rd_data_out=0, frames_done_out=0, error_out=0. Memory contents are not cleared. The partial frame is discarded, and the upstream producer restarts from column 0.

## Timing
- dda_out_tready_out is decoded from the registered state, so it has no combinational path from tvalid.
- It drops in the cycle after the tlast beat is accepted.
- It rises in the cycle after frame_start_in is sampled in DONE.
- A write becomes readable only after the swap. The minimum path from tlast acceptance to readability is 2 cycles: tlast accept → DONE, then frame_start_in → swap.
- Read latency is exactly 2 cycles: rd_en_in in cycle t gives rd_valid_out=1 and rd_data_out in cycle t+2. Back-to-back reads are sustained one per cycle.
- Sustained input rate is one beat per cycle while in FILL.

## Configuration
- COLUMN_BUFFER_STATS_EN defined:
  - frames_done_out counts swaps, wrapping at 16 bits.
  - error_out sets on an out-of-range hcount or a miscounted tlast and clears only on reset.
- COLUMN_BUFFER_STATS_EN undefined: frames_done_out and error_out are tied to 0, and the error and frame counters are not built. Buffering behaviour is identical.

## Test plan
- Full frame, no stats:
  - Stimulus: 320 beats with hcount 0..319, lineHeight=hcount[7:0], tlast on 319; then frame_start_in.
  - Required: tready low from the cycle after beat 319 until the swap. frame_ready_out=1. Reading address 5 returns lineHeight 5 at t+2.
- Backpressure:
  - Stimulus: hold tvalid high after tlast.
  - Required: no beat is accepted while in DONE. Beat 0 of the next frame is accepted the cycle after frame_start_in. The old read bank data stays readable until the second swap.
- Simultaneous events:
  - Stimulus: frame_start_in in the same cycle as the tlast beat is accepted.
  - Required: no swap, and frame_ready_out stays 0 on the first frame. The next frame_start_in swaps.
- Errors (stats on):
  - Stimulus: a beat with hcount 400; and separately, tlast on the 100th beat.
  - Required: error_out=1 in both cases. Address 400 is not written, and reading address 400 returns 0.
- Reset mid-frame:
  - Stimulus: assert rst_in asynchronously after 150 beats.
  - Required: all outputs go to their reset values immediately, tready=1 after release, and frames_done_out=0.

Source files
------------

// File: rtl/ray_column_buffer_if.sv
// rtl/ray_column_buffer_if.sv - DDA ray stream, renderer read port and status bundle for ray_column_buffer
interface ray_column_buffer_if #(
  parameter int REC_WIDTH = 29
);
  // DDA result stream
  logic                 dda_out_tvalid_in;
  logic [37:0]          dda_out_tdata_in;
  logic                 dda_out_tlast_in;
  logic                 dda_out_tready_out;
  // renderer side
  logic                 frame_start_in;
  logic                 rd_en_in;
  logic [8:0]           rd_addr_in;
  logic                 rd_valid_out;
  logic [REC_WIDTH-1:0] rd_data_out;
  logic                 frame_ready_out;
  // statistics
  logic [15:0]          frames_done_out;
  logic                 error_out;

  modport slave (
    input  dda_out_tvalid_in, dda_out_tdata_in, dda_out_tlast_in,
    input  frame_start_in, rd_en_in, rd_addr_in,
    output dda_out_tready_out, rd_valid_out, rd_data_out, frame_ready_out,
    output frames_done_out, error_out
  );

  modport master (
    output dda_out_tvalid_in, dda_out_tdata_in, dda_out_tlast_in,
    output frame_start_in, rd_en_in, rd_addr_in,
    input  dda_out_tready_out, rd_valid_out, rd_data_out, frame_ready_out,
    input  frames_done_out, error_out
  );
endinterface

// File: rtl/ray_column_buffer.sv
// rtl/ray_column_buffer.sv - double-buffered ray column store between DDA and renderer; COLUMN_BUFFER_STATS_EN adds frame/error stats
module ray_column_buffer #(
  parameter int SCREEN_WIDTH = 320,
  parameter int REC_WIDTH    = 29
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  ray_column_buffer_if.slave bus
);

  localparam logic [8:0] LP_WIDTH = 9'(SCREEN_WIDTH);
  localparam logic [8:0] LP_LAST  = 9'(SCREEN_WIDTH - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_wr_bank;
  logic                 w_rd_bank;
  logic [8:0]           r_col_cnt;
  logic                 r_frame_ready;

  logic                 w_tready;
  logic                 w_accept;
  logic                 w_swap;
  logic [8:0]           w_hcount;
  logic                 w_hcount_ok;
  logic                 w_write;
  logic [8:0]           w_wr_idx;
  logic [REC_WIDTH-1:0] w_wr_data;

  logic                 w_rd_addr_ok;
  logic [8:0]           w_rd_idx;
  logic [REC_WIDTH-1:0] r_rd_q;
  logic                 r_rd_en_s1;
  logic                 r_rd_zero_s1;
  logic                 r_rd_valid;
  logic [REC_WIDTH-1:0] r_rd_data;

  logic [REC_WIDTH-1:0] r_mem0 [SCREEN_WIDTH];
  logic [REC_WIDTH-1:0] r_mem1 [SCREEN_WIDTH];

  // The two banks are always opposite, so only the write selector is stored.
  assign w_rd_bank   = ~r_wr_bank;
  assign w_accept    = bus.dda_out_tvalid_in && w_tready;
  assign w_swap      = (r_state == ST_DONE) && bus.frame_start_in;
  assign w_hcount    = bus.dda_out_tdata_in[37:29];
  assign w_hcount_ok = (w_hcount < LP_WIDTH);
  assign w_write     = w_accept && w_hcount_ok;
  assign w_wr_idx    = w_hcount_ok ? w_hcount : 9'd0;
  assign w_wr_data   = bus.dda_out_tdata_in[REC_WIDTH-1:0];

  assign w_rd_addr_ok = (bus.rd_addr_in < LP_WIDTH);
  assign w_rd_idx     = w_rd_addr_ok ? bus.rd_addr_in : 9'd0;

  // FSM state register
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: fill until the tlast beat, then wait for the renderer's frame boundary
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_accept && bus.dda_out_tlast_in) w_state_nxt = ST_DONE;
      ST_DONE: if (bus.frame_start_in)               w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // FSM outputs: ready is decoded purely from the registered state
  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      ST_FILL: w_tready = 1'b1;
      ST_DONE: w_tready = 1'b0;
      default: w_tready = 1'b0;
    endcase
  end

  // Bank selection, column counting and frame-ready flag
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_bank     <= 1'b0;
      r_col_cnt     <= 9'd0;
      r_frame_ready <= 1'b0;
    end else if (w_swap) begin
      r_wr_bank     <= ~r_wr_bank;
      r_col_cnt     <= 9'd0;
      r_frame_ready <= 1'b1;
    end else if (w_accept) begin
      r_col_cnt     <= r_col_cnt + 9'd1;
    end
  end

  // Bank storage: synchronous write, registered read; contents survive reset
  always_ff @(posedge pixel_clk_in) begin
    if (w_write && !r_wr_bank) r_mem0[w_wr_idx] <= w_wr_data;
    if (w_write &&  r_wr_bank) r_mem1[w_wr_idx] <= w_wr_data;
    if (bus.rd_en_in)          r_rd_q <= w_rd_bank ? r_mem1[w_rd_idx] : r_mem0[w_rd_idx];
  end

  // Read stage 1: remember the request and whether it must return zero
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_en_s1   <= 1'b0;
      r_rd_zero_s1 <= 1'b0;
    end else begin
      r_rd_en_s1   <= bus.rd_en_in;
      r_rd_zero_s1 <= !w_rd_addr_ok || !r_frame_ready;
    end
  end

  // Read stage 2: present the record, forcing zero for invalid or pre-frame reads
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= r_rd_en_s1;
      r_rd_data  <= (r_rd_en_s1 && !r_rd_zero_s1) ? r_rd_q : '0;
    end
  end

  assign bus.dda_out_tready_out = w_tready;
  assign bus.rd_valid_out       = r_rd_valid;
  assign bus.rd_data_out        = r_rd_data;
  assign bus.frame_ready_out    = r_frame_ready;

`ifdef COLUMN_BUFFER_STATS_EN
  logic [15:0] r_frames_done;
  logic        r_error;
  logic        w_err_evt;

  assign w_err_evt = w_accept &&
                     (!w_hcount_ok || (bus.dda_out_tlast_in && (r_col_cnt != LP_LAST)));

  // Swap counter and sticky protocol error
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_frames_done <= 16'd0;
      r_error       <= 1'b0;
    end else begin
      if (w_swap)    r_frames_done <= r_frames_done + 16'd1;
      if (w_err_evt) r_error       <= 1'b1;
    end
  end

  assign bus.frames_done_out = r_frames_done;
  assign bus.error_out       = r_error;
`else
  assign bus.frames_done_out = 16'd0;
  assign bus.error_out       = 1'b0;
`endif

endmodule

// File: tb/tb_ray_column_buffer.sv
// tb/tb_ray_column_buffer.sv - directed self-checking bench for ray_column_buffer
module tb_ray_column_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ray_column_buffer_if #(.REC_WIDTH(29)) bus ();

  ray_column_buffer #(.SCREEN_WIDTH(320), .REC_WIDTH(29)) dut (
    .pixel_clk_in(clk),
    .rst_in      (rst),
    .bus         (bus)
  );

`ifdef COLUMN_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [37:0] mk_beat(input int col, input int tag);
    return {9'(col), 8'(col), 1'(col), 4'(col), 8'(tag), 8'(col)};
  endfunction

  function automatic logic [28:0] rec(input int col, input int tag);
    logic [37:0] b;
    b = mk_beat(col, tag);
    return b[28:0];
  endfunction

  function automatic logic [15:0] exp_frames(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int first, input int n, input int tag,
                            input bit last_on_end, input bit fs_on_end, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      bus.dda_out_tvalid_in = 1'b1;
      bus.dda_out_tdata_in  = mk_beat(first + i, tag);
      bus.dda_out_tlast_in  = last_on_end && (i == n - 1);
      bus.frame_start_in    = fs_on_end && (i == n - 1);
      if (bus.dda_out_tready_out !== 1'b1) stalls++;
      tick;
    end
    bus.dda_out_tvalid_in = 1'b0;
    bus.dda_out_tlast_in  = 1'b0;
    bus.frame_start_in    = 1'b0;
  endtask

  task automatic do_read(input int addr, output logic v, output logic [28:0] d);
    bus.rd_en_in   = 1'b1;
    bus.rd_addr_in = 9'(addr);
    tick;
    bus.rd_en_in   = 1'b0;
    tick;
    v = bus.rd_valid_out;
    d = bus.rd_data_out;
  endtask

  task automatic pulse_fs;
    bus.frame_start_in = 1'b1;
    tick;
    bus.frame_start_in = 1'b0;
  endtask

  task automatic test_reset;
    logic v; logic [28:0] d;
    tick; tick;
    n_cmp++; if (bus.dda_out_tready_out !== 1'b1) begin n_bad++; $display("FAIL reset_tready: got %b want 1", bus.dda_out_tready_out); end
    n_cmp++; if (bus.frame_ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_frame_ready: got %b want 0", bus.frame_ready_out); end
    n_cmp++; if (bus.rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid_out); end
    n_cmp++; if (bus.rd_data_out !== 29'd0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data_out); end
    n_cmp++; if (bus.frames_done_out !== 16'd0) begin n_bad++; $display("FAIL reset_frames_done: got %0d want 0", bus.frames_done_out); end
    n_cmp++; if (bus.error_out !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", bus.error_out); end
    rst = 1'b0;
    tick;
    do_read(5, v, d);
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL prefirst_rd_valid: got %b want 1", v); end
    n_cmp++; if (d !== 29'd0) begin n_bad++; $display("FAIL prefirst_rd_data: got %h want 0", d); end
  endtask

  task automatic test_simultaneous;
    int st; logic v; logic [28:0] d;
    send_beats(0, 320, 1, 1'b1, 1'b1, st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL sim_stalls: got %0d want 0", st); end
    n_cmp++; if (bus.dda_out_tready_out !== 1'b0) begin n_bad++; $display("FAIL sim_tready_done: got %b want 0", bus.dda_out_tready_out); end
    n_cmp++; if (bus.frame_ready_out !== 1'b0) begin n_bad++; $display("FAIL sim_no_swap: got %b want 0", bus.frame_ready_out); end
    tick;
    n_cmp++; if (bus.frame_ready_out !== 1'b0) begin n_bad++; $display("FAIL sim_still_no_swap: got %b want 0", bus.frame_ready_out); end
    pulse_fs;
    n_cmp++; if (bus.dda_out_tready_out !== 1'b1) begin n_bad++; $display("FAIL sim_tready_after_swap: got %b want 1", bus.dda_out_tready_out); end
    n_cmp++; if (bus.frame_ready_out !== 1'b1) begin n_bad++; $display("FAIL sim_frame_ready: got %b want 1", bus.frame_ready_out); end
    n_cmp++; if (bus.frames_done_out !== exp_frames(1)) begin n_bad++; $display("FAIL sim_frames_done: got %0d want %0d", bus.frames_done_out, exp_frames(1)); end
    do_read(5, v, d);
    n_cmp++; if (v !== 1'b1 || d !== rec(5, 1)) begin n_bad++; $display("FAIL sim_read5: got %b/%h want 1/%h", v, d, rec(5, 1)); end
    do_read(319, v, d);
    n_cmp++; if (d !== rec(319, 1)) begin n_bad++; $display("FAIL sim_read319: got %h want %h", d, rec(319, 1)); end
    do_read(320, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 29'd0) begin n_bad++; $display("FAIL sim_read320: got %b/%h want 1/0", v, d); end
  endtask

  task automatic test_full_backpressure;
    int st; int busy; logic v; logic [28:0] d;
    send_beats(0, 320, 2, 1'b1, 1'b0, st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL full_stalls: got %0d want 0", st); end
    bus.dda_out_tvalid_in = 1'b1;
    bus.dda_out_tdata_in  = mk_beat(0, 3);
    busy = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dda_out_tready_out !== 1'b0) busy++;
      tick;
    end
    n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL full_tready_low_in_done: got %0d ready cycles want 0", busy); end
    do_read(5, v, d);
    n_cmp++; if (d !== rec(5, 1)) begin n_bad++; $display("FAIL full_old_bank_before_swap: got %h want %h", d, rec(5, 1)); end
    bus.frame_start_in = 1'b1;
    tick;
    bus.frame_start_in = 1'b0;
    n_cmp++; if (bus.dda_out_tready_out !== 1'b1) begin n_bad++; $display("FAIL full_tready_rise: got %b want 1", bus.dda_out_tready_out); end
    n_cmp++; if (bus.frames_done_out !== exp_frames(2)) begin n_bad++; $display("FAIL full_frames_done: got %0d want %0d", bus.frames_done_out, exp_frames(2)); end
    tick;
    send_beats(1, 99, 3, 1'b1, 1'b0, st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL short_stalls: got %0d want 0", st); end
    n_cmp++; if (bus.dda_out_tready_out !== 1'b0) begin n_bad++; $display("FAIL short_done: got %b want 0", bus.dda_out_tready_out); end
    n_cmp++; if (bus.error_out !== STATS) begin n_bad++; $display("FAIL short_tlast_error: got %b want %b", bus.error_out, STATS); end
    bus.rd_en_in = 1'b1; bus.rd_addr_in = 9'd10; tick;
    bus.rd_addr_in = 9'd11; tick;
    n_cmp++; if (bus.rd_valid_out !== 1'b1 || bus.rd_data_out !== rec(10, 2)) begin n_bad++; $display("FAIL b2b_read10: got %b/%h want 1/%h", bus.rd_valid_out, bus.rd_data_out, rec(10, 2)); end
    bus.rd_addr_in = 9'd12; tick;
    n_cmp++; if (bus.rd_valid_out !== 1'b1 || bus.rd_data_out !== rec(11, 2)) begin n_bad++; $display("FAIL b2b_read11: got %b/%h want 1/%h", bus.rd_valid_out, bus.rd_data_out, rec(11, 2)); end
    bus.rd_en_in = 1'b0; tick;
    n_cmp++; if (bus.rd_valid_out !== 1'b1 || bus.rd_data_out !== rec(12, 2)) begin n_bad++; $display("FAIL b2b_read12: got %b/%h want 1/%h", bus.rd_valid_out, bus.rd_data_out, rec(12, 2)); end
    tick;
    n_cmp++; if (bus.rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_drop: got %b want 0", bus.rd_valid_out); end
    pulse_fs;
    n_cmp++; if (bus.frames_done_out !== exp_frames(3)) begin n_bad++; $display("FAIL short_frames_done: got %0d want %0d", bus.frames_done_out, exp_frames(3)); end
    do_read(0, v, d);
    n_cmp++; if (d !== rec(0, 3)) begin n_bad++; $display("FAIL short_read0: got %h want %h", d, rec(0, 3)); end
    do_read(99, v, d);
    n_cmp++; if (d !== rec(99, 3)) begin n_bad++; $display("FAIL short_read99: got %h want %h", d, rec(99, 3)); end
    do_read(150, v, d);
    n_cmp++; if (d !== rec(150, 1)) begin n_bad++; $display("FAIL short_read150_stale: got %h want %h", d, rec(150, 1)); end
  endtask

  task automatic test_reset_midframe;
    int st; logic v; logic [28:0] d;
    send_beats(0, 149, 5, 1'b0, 1'b0, st);
    bus.dda_out_tvalid_in = 1'b1;
    bus.dda_out_tdata_in  = mk_beat(149, 5);
    bus.rd_en_in = 1'b1; bus.rd_addr_in = 9'd5;
    tick;
    bus.dda_out_tvalid_in = 1'b0;
    bus.rd_en_in = 1'b0;
    tick;
    n_cmp++; if (bus.rd_valid_out !== 1'b1 || bus.rd_data_out !== rec(5, 3)) begin n_bad++; $display("FAIL mid_read_before_rst: got %b/%h want 1/%h", bus.rd_valid_out, bus.rd_data_out, rec(5, 3)); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.dda_out_tready_out !== 1'b1) begin n_bad++; $display("FAIL mid_rst_tready: got %b want 1", bus.dda_out_tready_out); end
    n_cmp++; if (bus.frame_ready_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_frame_ready: got %b want 0", bus.frame_ready_out); end
    n_cmp++; if (bus.rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rd_valid: got %b want 0", bus.rd_valid_out); end
    n_cmp++; if (bus.rd_data_out !== 29'd0) begin n_bad++; $display("FAIL mid_rst_rd_data: got %h want 0", bus.rd_data_out); end
    n_cmp++; if (bus.frames_done_out !== 16'd0) begin n_bad++; $display("FAIL mid_rst_frames_done: got %0d want 0", bus.frames_done_out); end
    n_cmp++; if (bus.error_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_error: got %b want 0", bus.error_out); end
    tick;
    rst = 1'b0;
    tick;
    n_cmp++; if (bus.dda_out_tready_out !== 1'b1) begin n_bad++; $display("FAIL mid_release_tready: got %b want 1", bus.dda_out_tready_out); end
    do_read(5, v, d);
    n_cmp++; if (d !== 29'd0) begin n_bad++; $display("FAIL mid_release_read: got %h want 0", d); end
  endtask

  task automatic test_out_of_range;
    int st; logic v; logic [28:0] d;
    send_beats(400, 1, 6, 1'b0, 1'b0, st);
    n_cmp++; if (bus.error_out !== STATS) begin n_bad++; $display("FAIL oor_error: got %b want %b", bus.error_out, STATS); end
    send_beats(1, 319, 6, 1'b1, 1'b0, st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL oor_stalls: got %0d want 0", st); end
    pulse_fs;
    n_cmp++; if (bus.frames_done_out !== exp_frames(1)) begin n_bad++; $display("FAIL oor_frames_done: got %0d want %0d", bus.frames_done_out, exp_frames(1)); end
    do_read(400, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 29'd0) begin n_bad++; $display("FAIL oor_read400: got %b/%h want 1/0", v, d); end
    do_read(0, v, d);
    n_cmp++; if (d !== rec(0, 3)) begin n_bad++; $display("FAIL oor_read0_untouched: got %h want %h", d, rec(0, 3)); end
    do_read(144, v, d);
    n_cmp++; if (d !== rec(144, 6)) begin n_bad++; $display("FAIL oor_read144: got %h want %h", d, rec(144, 6)); end
    do_read(5, v, d);
    n_cmp++; if (d !== rec(5, 6)) begin n_bad++; $display("FAIL oor_read5: got %h want %h", d, rec(5, 6)); end
  endtask

  initial begin
    bus.dda_out_tvalid_in = 1'b0;
    bus.dda_out_tdata_in  = '0;
    bus.dda_out_tlast_in  = 1'b0;
    bus.frame_start_in    = 1'b0;
    bus.rd_en_in          = 1'b0;
    bus.rd_addr_in        = '0;
    test_reset;
    test_simultaneous;
    test_full_backpressure;
    test_reset_midframe;
    test_out_of_range;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
